uart_frame_rx: RTL

//  Framed-packet receiver directly downstream of the UART RX FIFO. Pops bytes via
//  rx_empty/rd_uart/r_data, hunts for a start-of-frame byte, collects LEN + payload,

---
 rtl/uart_frame_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//
// Framed-packet receiver sitting directly behind a UART RX FIFO. It pops one
// byte per cycle whenever the FIFO is non-empty. It hunts for a start-of-frame
// byte, collects LEN and LEN payload bytes, and verifies an 8-bit
// two's-complement checksum. A good frame is then presented to the
// application on a valid/ready handshake. While a frame is being presented
// the FIFO is not popped, so backpressure propagates to the UART.
//
// Wire format : SOF, LEN, payload[LEN], CHK
// Frame valid : (LEN + sum(payload) + CHK) mod 256 == 0
//
// Parameters
//   MAX_LEN  largest accepted payload length (1..255)
//   SOF      start-of-frame byte
//   TIMEOUT  inter-byte timeout in clk cycles while mid-frame (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_empty   in   UART RX FIFO empty flag
//   r_data     in   UART RX FIFO head byte, valid when !rx_empty
//   rd_uart    out  pop strobe to the FIFO (combinational)
//   frm_valid  out  a complete, checked frame is being presented
//   frm_ready  in   application accepts the presented frame
//   frm_len    out  payload length of the presented frame
//   frm_data   out  payload, byte i at [8i+7:8i]; bytes >= frm_len read 0
//   err_chk    out  one-cycle pulse: checksum mismatch
//   err_len    out  one-cycle pulse: LEN larger than MAX_LEN
//   err_tmo    out  one-cycle pulse: inter-byte timeout mid-frame
//
// Optional feature (macro UART_FRAME_STATS_EN)
//   frm_cnt    out  frames handed off (valid && ready), saturating 16 bits
//   err_cnt    out  error pulses of any kind, saturating 16 bits
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int          TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_empty,
    input  logic [7:0]                     r_data,
    output logic                           rd_uart,
    output logic                           frm_valid,
    input  logic                           frm_ready,
    output logic [$clog2(MAX_LEN+1)-1:0]   frm_len,
    output logic [8*MAX_LEN-1:0]           frm_data,
    output logic                           err_chk,
    output logic                           err_len,
    output logic                           err_tmo
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0]                    frm_cnt,
    output logic [15:0]                    err_cnt
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   cnt;
    logic [7:0]         sum;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic [7:0]         chk_total;

    // The pop strobe is combinational so a byte can be consumed every cycle.
    // Reset is folded in so the FIFO is never popped while reset is held.
    assign rd_uart   = rst_n && !rx_empty && (state != S_HOLD);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign chk_total = 8'(sum + r_data);

    // Main frame FSM. Every output except rd_uart is registered here.
    // Error pulses default low every cycle so each one lasts exactly a cycle.
    // A consumed byte always takes precedence over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_reg   <= '0;
            cnt       <= '0;
            sum       <= '0;
            tmo_cnt   <= '0;
            frm_valid <= 1'b0;
            frm_len   <= '0;
            frm_data  <= '0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            err_tmo <= 1'b0;

            case (state)
                S_IDLE: begin
                    sum     <= '0;
                    cnt     <= '0;
                    tmo_cnt <= '0;
                    if (rd_uart && (r_data == SOF)) begin
                        state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (rd_uart) begin
                        tmo_cnt <= '0;
                        if (r_data > MAX_LEN_B) begin
                            err_len <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            // The length byte is part of the checksum, so it seeds the sum.
                            frm_data <= '0;
                            frm_len  <= LEN_W'(r_data);
                            len_reg  <= LEN_W'(r_data);
                            sum      <= r_data;
                            cnt      <= '0;
                            state    <= (r_data == 8'h00) ? S_CHK : S_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_PAYLOAD: begin
                    if (rd_uart) begin
                        tmo_cnt                    <= '0;
                        frm_data[8*int'(cnt) +: 8] <= r_data;
                        sum                        <= 8'(sum + r_data);
                        cnt                        <= cnt + LEN_W'(1);
                        if (cnt == len_reg - LEN_W'(1)) begin
                            state <= S_CHK;
                        end
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_CHK: begin
                    if (rd_uart) begin
                        tmo_cnt <= '0;
                        if (chk_total == 8'h00) begin
                            frm_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end else if (tmo_hit) begin
                        err_tmo <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_HOLD: begin
                    // The frame stays frozen until it is accepted. The next byte
                    // is popped in IDLE on the following cycle.
                    if (frm_ready) begin
                        frm_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FRAME_STATS_EN
    // Saturating statistics counters. The registered error pulses are
    // mutually exclusive, so an OR of them counts each error once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (frm_valid && frm_ready && (frm_cnt != 16'hFFFF)) begin
                frm_cnt <= frm_cnt + 16'd1;
            end
            if ((err_chk || err_len || err_tmo) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
